cpu_lsu: RTL and testbench
==========================

// Module: cpu_lsu
// PURPOSE
// - Load/store unit: the memory-side responder to the decoder's mem_write strobes and data_ext_control.
// - Takes one CPU data request and aligns strobes/data to the byte address.
// - Runs one valid/ready bus transaction, stalling the CPU until it completes.
// - Extends the load data and returns it, registered, to writeback.
// PARAMETERS
// - ADDR_WIDTH  32  byte-address width of req_addr and bus_addr
// PORTS
// - clk        in   1   clock; all state updates on posedge
// - rst        in   1   reset, asynchronous, active-high
// - req_valid  in   1   CPU has a load or store in the MEM slot
// - req_write  in   4   store mask from decoder: 0001 SB, 0011 SH, 1111 SW, 0000 = load
// - req_ext    in   3   load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
// - req_addr   in   ADDR_WIDTH  byte address (ALU result)
// - req_wdata  in   32  store data (rs2, unshifted)
// - stall      out  1   hold the pipeline
// - done       out  1   one-cycle pulse: access complete, rdata valid
// - rdata      out  32  extended load data
// - fault      out  1   misaligned access (only with the macro)
// - bus_valid  out  1   bus request
// - bus_ready  in   1   bus accept; bus_rdata is valid in the same cycle
// - bus_we     out  1   1 = write
// - bus_addr   out  ADDR_WIDTH  word address, bits [1:0] = 0
// - bus_wstrb  out  4   byte strobes
// - bus_wdata  out  32  lane-aligned write data
// - bus_rdata  in   32  raw read word
// BEHAVIOUR
// - Reset values:
//   - state=IDLE
//   - stall, done, fault, bus_valid, bus_we = 0
//   - rdata, bus_addr, bus_wstrb, bus_wdata = 0
//   - Reset mid-transaction drops bus_valid at once; no completion is reported.
// - FSM IDLE -> BUS -> DONE -> IDLE. stall = req_valid & (state != DONE), combinational.
// - IDLE, req_valid=1:
//   - Capture the request; go to BUS.
//   - off = req_addr[1:0]
//   - bus_wstrb = req_write << off
//   - bus_wdata = req_wdata << 8*off
//   - bus_we = |req_write
//   - bus_addr = {req_addr[ADDR_WIDTH-1:2], 2'b00}
// - BUS:
//   - bus_valid=1; all bus outputs are held stable until bus_ready.
//   - On bus_ready: register the extended load data into rdata, then go to DONE.
// - DONE: done=1 and stall=0 for exactly one cycle; go to IDLE. A req_valid seen in DONE is ignored.
// - Minimum latency: 3 cycles from request accept to done (bus_ready in the first BUS cycle).
// - Extension, applied to bus_rdata >> 8*off:
//   - LB/LH: sign-extend bits [7:0]/[15:0].
//   - LBU/LHU: zero-extend.
//   - LW: pass through.
//   - Stores leave rdata unchanged.
//   - Undefined req_ext (011, 110, 111): rdata = raw word.
// - Shift overflow: bits shifted past bit 31 (or past strobe bit 3) are dropped.
// CONFIGURATION
// - CPU_LSU_MISALIGN_TRAP_EN defined:
//   - Misaligned means: halfword with off=3, or word with off!=0.
//   - A misaligned request in IDLE skips BUS and goes straight to DONE.
//   - fault=1 with done for that one cycle; bus_valid stays 0; rdata is unchanged.
// - CPU_LSU_MISALIGN_TRAP_EN undefined:
//   - fault is tied to 0.
//   - Misaligned requests proceed with truncated strobes/data.
// TESTING
// - SW addr=0x100 wdata=0xDEADBEEF, bus_ready after 2 cycles -> bus_wstrb=1111, bus_addr=0x100; done 1 cycle after handshake.
// - SB addr=0x103 wdata=0x000000A5 -> bus_wstrb=1000, bus_wdata=0xA5000000, bus_we=1.
// - LB addr=0x202, bus_rdata=0x00800000 -> rdata=0xFFFFFF80. LBU at the same address -> rdata=0x00000080.
// - LH addr=0x202, bus_rdata=0x8001xxxx -> rdata=0xFFFF8001. LW with bus_ready held low 5 cycles -> stall=1 throughout, bus outputs stable.
// - rst pulsed while in BUS -> bus_valid=0 immediately; no done pulse; next request is serviced normally.
// - Macro on, LW addr=0x102 -> no bus_valid; done=1 and fault=1 together on the 2nd cycle. Macro off -> fault stays 0.

Source files
------------

// File: rtl/cpu_lsu_if.sv
// rtl/cpu_lsu_if.sv - word bus between the load/store unit (master) and data memory (slave)
interface cpu_lsu_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  bus_valid;
  logic                  bus_ready;
  logic                  bus_we;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [3:0]            bus_wstrb;
  logic [31:0]           bus_wdata;
  logic [31:0]           bus_rdata;

  modport master (
    output bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata,
    input  bus_ready, bus_rdata
  );

  modport slave (
    input  bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata,
    output bus_ready, bus_rdata
  );
endinterface

// File: rtl/cpu_lsu.sv
// rtl/cpu_lsu.sv - load/store unit: aligns one CPU data access onto the word bus and extends load data (option: CPU_LSU_MISALIGN_TRAP_EN)
module cpu_lsu #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [3:0]            req_write,
  input  logic [2:0]            req_ext,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  stall,
  output logic                  done,
  output logic [31:0]           rdata,
  output logic                  fault,
  cpu_lsu_if.master             bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic                  capture;
  logic                  misaligned;
  logic [1:0]            off;

  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [3:0]            wstrb_q;
  logic [31:0]           wdata_q;
  logic [1:0]            off_q;
  logic [2:0]            ext_q;
  logic [31:0]           rdata_q;

  logic [31:0]           shifted;
  logic [31:0]           load_val;

  assign off = req_addr[1:0];

`ifdef CPU_LSU_MISALIGN_TRAP_EN
  logic is_half;
  logic is_word;
  logic fault_q;

  // Classify the access size and flag ones that cross a word boundary
  always_comb begin
    is_half    = (req_write == 4'b0011) ||
                 ((req_write == 4'b0000) && ((req_ext == 3'b001) || (req_ext == 3'b101)));
    is_word    = (req_write == 4'b1111) ||
                 ((req_write == 4'b0000) && (req_ext == 3'b010));
    misaligned = (is_half && (off == 2'd3)) || (is_word && (off != 2'd0));
  end

  // Remember whether the accepted request trapped, reported alongside done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else if (capture) begin
      fault_q <= misaligned;
    end
  end

  assign fault = fault_q & (state == DONE);
`else
  assign misaligned = 1'b0;
  assign fault      = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: accept in IDLE, wait for the bus handshake, report for one cycle
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          capture   = 1'b1;
          state_nxt = misaligned ? DONE : BUS;
        end
      end
      BUS: begin
        if (bus.bus_ready) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Bring the addressed lanes down to bit 0 and extend per the load type
  always_comb begin
    shifted = bus.bus_rdata >> {off_q, 3'b000};
    case (ext_q)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  load_val = shifted;
      3'b100:  load_val = {24'h000000, shifted[7:0]};
      3'b101:  load_val = {16'h0000, shifted[15:0]};
      default: load_val = bus.bus_rdata;
    endcase
  end

  // Capture the lane-aligned request on accept; latch load data on the handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wstrb_q <= 4'h0;
      wdata_q <= 32'h0;
      off_q   <= 2'd0;
      ext_q   <= 3'd0;
      rdata_q <= 32'h0;
    end else begin
      if (capture) begin
        we_q    <= |req_write;
        addr_q  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
        wstrb_q <= req_write << off;
        wdata_q <= req_wdata << {off, 3'b000};
        off_q   <= off;
        ext_q   <= req_ext;
      end
      if ((state == BUS) && bus.bus_ready && !we_q) begin
        rdata_q <= load_val;
      end
    end
  end

  assign bus.bus_valid = (state == BUS);
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wstrb = wstrb_q;
  assign bus.bus_wdata = wdata_q;

  assign rdata = rdata_q;
  assign done  = (state == DONE);
  assign stall = req_valid & (state != DONE);

endmodule

// File: tb/tb_cpu_lsu.sv
// tb/tb_cpu_lsu.sv - self-checking bench for cpu_lsu against a transaction-level model
module tb_cpu_lsu;

`ifdef CPU_LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [3:0]  req_write;
  logic [2:0]  req_ext;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic        fault;

  cpu_lsu_if #(.ADDR_WIDTH(32)) bus ();

  cpu_lsu #(.ADDR_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_ext   (req_ext),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .stall     (stall),
    .done      (done),
    .rdata     (rdata),
    .fault     (fault),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // model state: what the outputs must be right now
  logic        m_expect_bus  = 1'b0;
  logic        m_expect_done = 1'b0;
  logic        m_fault       = 1'b0;
  logic [31:0] m_rdata       = 32'h0;
  logic        m_we          = 1'b0;
  logic [31:0] m_addr        = 32'h0;
  logic [3:0]  m_wstrb       = 4'h0;
  logic [31:0] m_wdata       = 32'h0;
  int          last_req_cyc  = 0;

  // observations of the DUT, written only by the monitor
  int          mon_bus_total  = 0;
  int          mon_done_total = 0;
  int          mon_done_cyc   = 0;
  int          mon_hs_cyc     = 0;
  logic [31:0] mon_done_rdata = 32'h0;
  logic        mon_done_fault = 1'b0;
  logic        prev_bv        = 1'b0;
  logic        cap_we         = 1'b0;
  logic [31:0] cap_addr       = 32'h0;
  logic [3:0]  cap_wstrb      = 4'h0;
  logic [31:0] cap_wdata      = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int access_bytes(input logic [3:0] w, input logic [2:0] ext);
    if (w == 4'b0001) return 1;
    if (w == 4'b0011) return 2;
    if (w == 4'b1111) return 4;
    if (w != 4'b0000) return 0;
    case (ext)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic logic [31:0] load_model(input logic [2:0] ext, input int off, input logic [31:0] word);
    logic [31:0] w;
    int          v;
    w = word >> (8 * off);
    case (ext)
      3'b000: begin v = int'(w % 256);   if (v >= 128)   v = v - 256;   return 32'(v); end
      3'b001: begin v = int'(w % 65536); if (v >= 32768) v = v - 65536; return 32'(v); end
      3'b010: return w;
      3'b100: return w % 256;
      3'b101: return w % 65536;
      default: return word;
    endcase
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // compare process plus monitor, sampled on the falling edge
  initial forever begin
    @(negedge clk);
    if (rst === 1'b0) begin
      chk("done", done, m_expect_done);
      chk("stall", stall, req_valid & ~m_expect_done);
      chk("fault", fault, m_expect_done & m_fault);
      chk("bus_valid", bus.bus_valid, m_expect_bus);
      chk("rdata", rdata, m_rdata);
      if (m_expect_bus) begin
        chk("bus_we", bus.bus_we, m_we);
        chk("bus_addr", bus.bus_addr, m_addr);
        chk("bus_wstrb", bus.bus_wstrb, m_wstrb);
        chk("bus_wdata", bus.bus_wdata, m_wdata);
      end
      if (bus.bus_valid) begin
        mon_bus_total++;
        if (!prev_bv) begin
          cap_we    = bus.bus_we;
          cap_addr  = bus.bus_addr;
          cap_wstrb = bus.bus_wstrb;
          cap_wdata = bus.bus_wdata;
        end
        if (bus.bus_ready) mon_hs_cyc = cyc;
      end
      if (done) begin
        mon_done_total++;
        mon_done_cyc   = cyc;
        mon_done_rdata = rdata;
        mon_done_fault = fault;
      end
    end
    prev_bv = bus.bus_valid;
  end

  // one full CPU access: request, bus wait states, handshake, done cycle, idle gap
  task automatic do_req(input logic [3:0] w, input logic [2:0] ext, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rword, input int waits);
    int          off;
    int          sz;
    bit          trap;
    logic [31:0] tmp;
    off  = int'(addr % 4);
    sz   = access_bytes(w, ext);
    trap = TRAP && (sz > 1) && (off + sz > 4);
    m_we    = (w != 4'b0000);
    m_addr  = addr - 32'(off);
    m_wstrb = 4'((int'(w) << off) % 16);
    tmp     = wd << (8 * off);
    m_wdata = tmp;
    req_write     = w;
    req_ext       = ext;
    req_addr      = addr;
    req_wdata     = wd;
    bus.bus_rdata = ~rword;
    last_req_cyc  = cyc;
    req_valid     = 1'b1;
    @(posedge clk); #1;
    if (trap) begin
      m_fault       = 1'b1;
      m_expect_done = 1'b1;
    end else begin
      m_expect_bus = 1'b1;
      repeat (waits) begin
        @(posedge clk); #1;
      end
      bus.bus_ready = 1'b1;
      bus.bus_rdata = rword;
      @(posedge clk); #1;
      bus.bus_ready = 1'b0;
      bus.bus_rdata = ~rword;
      m_expect_bus  = 1'b0;
      m_expect_done = 1'b1;
      if (w == 4'b0000) m_rdata = load_model(ext, off, rword);
    end
    @(posedge clk); #1;
    m_expect_done = 1'b0;
    m_fault       = 1'b0;
    req_valid     = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  int bus_before;
  int done_before;

  initial begin
    rst           = 1'b1;
    req_valid     = 1'b0;
    req_write     = 4'h0;
    req_ext       = 3'h0;
    req_addr      = 32'h0;
    req_wdata     = 32'h0;
    bus.bus_ready = 1'b0;
    bus.bus_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_stall", stall, 0);
    chk("reset_done", done, 0);
    chk("reset_fault", fault, 0);
    chk("reset_bus_valid", bus.bus_valid, 0);
    chk("reset_bus_we", bus.bus_we, 0);
    chk("reset_rdata", rdata, 0);
    chk("reset_bus_addr", bus.bus_addr, 0);
    chk("reset_bus_wstrb", bus.bus_wstrb, 0);
    chk("reset_bus_wdata", bus.bus_wdata, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // SW aligned, two wait states
    bus_before = mon_bus_total;
    do_req(4'b1111, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 2);
    chk("sw_wstrb", cap_wstrb, 4'b1111);
    chk("sw_addr", cap_addr, 32'h100);
    chk("sw_wdata", cap_wdata, 32'hDEADBEEF);
    chk("sw_bus_cycles", 32'(mon_bus_total - bus_before), 3);
    chk("sw_done_after_hs", 32'(mon_done_cyc - mon_hs_cyc), 1);

    // SB to the top byte lane
    do_req(4'b0001, 3'b000, 32'h103, 32'h000000A5, 32'h0, 0);
    chk("sb_wstrb", cap_wstrb, 4'b1000);
    chk("sb_wdata", cap_wdata, 32'hA5000000);
    chk("sb_we", cap_we, 1);

    // byte loads, signed then unsigned
    do_req(4'b0000, 3'b000, 32'h202, 32'h0, 32'h00800000, 1);
    chk("lb_rdata", mon_done_rdata, 32'hFFFFFF80);
    chk("lb_addr", cap_addr, 32'h200);
    chk("lb_we", cap_we, 0);
    do_req(4'b0000, 3'b100, 32'h202, 32'h0, 32'h00800000, 0);
    chk("lbu_rdata", mon_done_rdata, 32'h00000080);

    // signed halfword from the upper half
    do_req(4'b0000, 3'b001, 32'h202, 32'h0, 32'h80011234, 0);
    chk("lh_rdata", mon_done_rdata, 32'hFFFF8001);

    // LW held off five cycles
    bus_before = mon_bus_total;
    do_req(4'b0000, 3'b010, 32'h204, 32'h0, 32'h12345678, 5);
    chk("lw_rdata", mon_done_rdata, 32'h12345678);
    chk("lw_bus_cycles", 32'(mon_bus_total - bus_before), 6);

    // LHU at minimum latency
    do_req(4'b0000, 3'b101, 32'h200, 32'h0, 32'hCAFE9ABC, 0);
    chk("lhu_rdata", mon_done_rdata, 32'h00009ABC);
    chk("min_latency", 32'(mon_done_cyc - last_req_cyc), 2);

    // SH to the upper half; a store must not disturb rdata
    do_req(4'b0010 + 4'b0001, 3'b001, 32'h102, 32'h1234BEEF, 32'h55555555, 0);
    chk("sh_wstrb", cap_wstrb, 4'b1100);
    chk("sh_wdata", cap_wdata, 32'hBEEF0000);
    chk("sh_rdata_kept", mon_done_rdata, 32'h00009ABC);

    // undefined extension returns the raw word
    do_req(4'b0000, 3'b011, 32'h201, 32'h0, 32'h11223344, 0);
    chk("undef_ext_rdata", mon_done_rdata, 32'h11223344);

    // reset while waiting on the bus
    done_before   = mon_done_total;
    req_write     = 4'b0000;
    req_ext       = 3'b010;
    req_addr      = 32'h300;
    m_we          = 1'b0;
    m_addr        = 32'h300;
    m_wstrb       = 4'h0;
    m_wdata       = 32'h0;
    req_valid     = 1'b1;
    @(posedge clk); #1;
    m_expect_bus = 1'b1;
    @(negedge clk);
    #2;
    rst          = 1'b1;
    req_valid    = 1'b0;
    m_expect_bus = 1'b0;
    m_rdata      = 32'h0;
    #1;
    chk("rst_bus_valid", bus.bus_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_rdata", rdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("rst_no_done", 32'(mon_done_total - done_before), 0);
    do_req(4'b0000, 3'b000, 32'h201, 32'h0, 32'h0000FF00, 0);
    chk("post_rst_lb", mon_done_rdata, 32'hFFFFFFFF);

    // misaligned word load
    bus_before = mon_bus_total;
    do_req(4'b0000, 3'b010, 32'h102, 32'h0, 32'hAABBCCDD, 0);
    if (TRAP) begin
      chk("mis_lw_bus_cycles", 32'(mon_bus_total - bus_before), 0);
      chk("mis_lw_fault", mon_done_fault, 1);
      chk("mis_lw_latency", 32'(mon_done_cyc - last_req_cyc), 1);
      chk("mis_lw_rdata_kept", mon_done_rdata, 32'hFFFFFFFF);
    end else begin
      chk("mis_lw_fault", mon_done_fault, 0);
      chk("mis_lw_rdata", mon_done_rdata, 32'h0000AABB);
    end

    // misaligned word store
    bus_before = mon_bus_total;
    do_req(4'b1111, 3'b010, 32'h101, 32'hDEADBEEF, 32'h0, 1);
    if (TRAP) begin
      chk("mis_sw_bus_cycles", 32'(mon_bus_total - bus_before), 0);
      chk("mis_sw_fault", mon_done_fault, 1);
    end else begin
      chk("mis_sw_wstrb", cap_wstrb, 4'b1110);
      chk("mis_sw_wdata", cap_wdata, 32'hADBEEF00);
    end

    // halfword store at offset 3
    bus_before = mon_bus_total;
    do_req(4'b0011, 3'b001, 32'h103, 32'h0000BEEF, 32'h0, 0);
    if (TRAP) begin
      chk("mis_sh_bus_cycles", 32'(mon_bus_total - bus_before), 0);
      chk("mis_sh_fault", mon_done_fault, 1);
    end else begin
      chk("mis_sh_wstrb", cap_wstrb, 4'b1000);
      chk("mis_sh_wdata", cap_wdata, 32'hEF000000);
    end

    // aligned halfword at offset 2 is never a trap
    do_req(4'b0000, 3'b001, 32'h206, 32'h0, 32'h7FFF0000, 0);
    chk("lh_off2_rdata", mon_done_rdata, 32'h00007FFF);
    chk("lh_off2_fault", mon_done_fault, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
